// File: rtl/kamikaze_fetch_queue_if.sv
// Fetch queue bus: instruction-memory port, redirect and decode handshake.
// master = fetch queue, slave = memory/decode environment.
interface kamikaze_fetch_queue_if;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_gnt_i;
  logic        im_rvalid_i;
  logic [31:0] im_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        is_compressed_instr_o;

  modport master (
    output im_req_o, im_addr_o,
    output instr_o, instr_pc_o,
    output instr_valid_o, is_compressed_instr_o,
    input  im_gnt_i, im_rvalid_i, im_data_i,
    input  redirect_i, redirect_pc_i,
    input  instr_ready_i
  );

  modport slave (
    input  im_req_o, im_addr_o,
    input  instr_o, instr_pc_o,
    input  instr_valid_o, is_compressed_instr_o,
    output im_gnt_i, im_rvalid_i, im_data_i,
    output redirect_i, redirect_pc_i,
    output instr_ready_i
  );
endinterface

// File: rtl/kamikaze_fetch_queue.sv
// Instruction fetch queue: 16-bit parcel ring fed by a word memory,
// realigning RVC/32-bit instructions for decode, with redirect flush.
module kamikaze_fetch_queue #(
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4
) (
  input logic clk_i,
  input logic rst_i,
  kamikaze_fetch_queue_if.master bus
);
  localparam int NP = 2 * DEPTH_WORDS;
  localparam int PW = $clog2(NP);
  localparam int CW = PW + 1;

  logic [15:0]   r_buf [NP];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic          r_drop_low;
  logic [31:0]   r_addr;
  logic [31:0]   r_pc;

  logic [PW-1:0] w_head1;
  logic [PW-1:0] w_tail1;
  logic [15:0]   w_p0;
  logic [15:0]   w_p1;
  logic          w_comp;
  logic          w_valid;
  logic [CW-1:0] w_words;
  logic [CW:0]   w_load;
  logic          w_req;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_dsc;
  logic          w_pop;
  logic [CW-1:0] w_push_n;
  logic [CW-1:0] w_pop_n;
  logic          w_unused;

  assign w_head1 = r_head + PW'(1);
  assign w_tail1 = r_tail + PW'(1);
  assign w_p0    = r_buf[r_head];
  assign w_p1    = r_buf[w_head1];
  assign w_comp  = (w_p0[1:0] != 2'b11);
  assign w_valid = (r_count >= CW'(2)) |
                   ((r_count != '0) & w_comp);

  // Stale responses still in flight occupy slots in the request cap.
  assign w_words = (r_count + CW'(1)) >> 1;
  assign w_load  = {1'b0, w_words} + {1'b0, r_out}
                 + {1'b0, r_disc};
  assign w_req   = rst_i & ~bus.redirect_i &
                   (w_load < (CW+1)'(DEPTH_WORDS));
  assign w_gnt   = w_req & bus.im_gnt_i;
  assign w_rsp   = bus.im_rvalid_i & (r_disc == '0);
  assign w_dsc   = bus.im_rvalid_i & (r_disc != '0);
  assign w_pop   = w_valid & bus.instr_ready_i;

  assign w_push_n = ~w_rsp     ? CW'(0) :
                    r_drop_low ? CW'(1) : CW'(2);
  assign w_pop_n  = ~w_pop     ? CW'(0) :
                    w_comp     ? CW'(1) : CW'(2);

  assign w_unused = bus.redirect_pc_i[0];

  assign bus.im_req_o   = w_req;
  assign bus.im_addr_o  = r_addr;
  assign bus.instr_pc_o = r_pc;
  assign bus.instr_valid_o = w_valid;
  assign bus.is_compressed_instr_o = w_valid & w_comp;
  assign bus.instr_o = ~w_valid ? 32'h0 :
                       w_comp   ? {16'h0, w_p0} :
                                  {w_p1, w_p0};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_disc     <= '0;
      r_drop_low <= BOOT_ADDR[1];
      r_addr     <= {BOOT_ADDR[31:2], 2'b00};
      r_pc       <= {BOOT_ADDR[31:1], 1'b0};
    end else if (bus.redirect_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_disc     <= r_disc + r_out + CW'(w_gnt)
                  - CW'(bus.im_rvalid_i);
      r_drop_low <= bus.redirect_pc_i[1];
      r_addr     <= {bus.redirect_pc_i[31:2], 2'b00};
      r_pc       <= {bus.redirect_pc_i[31:1], 1'b0};
    end else begin
      if (w_gnt)
        r_addr <= r_addr + 32'd4;
      if (w_dsc)
        r_disc <= r_disc - CW'(1);
      if (w_rsp)
        r_drop_low <= 1'b0;
      r_out   <= r_out + CW'(w_gnt) - CW'(w_rsp);
      r_tail  <= r_tail + w_push_n[PW-1:0];
      r_head  <= r_head + w_pop_n[PW-1:0];
      r_count <= r_count + w_push_n - w_pop_n;
      r_pc    <= r_pc + (32'(w_pop_n) << 1);
    end
  end

  // Parcel storage needs no reset; r_count gates every read.
  always_ff @(posedge clk_i) begin
    if (!bus.redirect_i && w_rsp) begin
      if (r_drop_low) begin
        r_buf[r_tail] <= bus.im_data_i[31:16];
      end else begin
        r_buf[r_tail]  <= bus.im_data_i[15:0];
        r_buf[w_tail1] <= bus.im_data_i[31:16];
      end
    end
  end
endmodule
